// File: rtl/rps_pkg.sv
// Shared types and constants for the rock-paper-scissors match path.
package rps_pkg;

  // One-hot move encoding used by the upstream win detectors
  localparam logic [2:0] PAPER    = 3'b100;
  localparam logic [2:0] ROCK     = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } match_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10,
    WIN_TIE  = 2'b11
  } match_winner_e;

endpackage

// File: rtl/rps_sat_counter.sv
// Up-counter with synchronous clear, enable and saturation at all-ones.
module rps_sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Clear wins over enable; the count holds once it reaches all-ones
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/rps_match_scorer.sv
// First-to-WIN_TARGET match scorer fed by per-round win flags.
// Optional build macro RPS_ROUND_LIMIT_EN: end the match after MAX_ROUNDS
// accepted rounds, deciding on score (or tie) if nobody reached the target.
module rps_match_scorer
  import rps_pkg::*;
#(
  parameter int WIN_TARGET = 3,
  parameter int SCORE_W    = 3,
  parameter int RND_W      = 8,
  parameter int MAX_ROUNDS = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               round_valid,
  output logic               round_ready,
  input  logic               winA,
  input  logic               winB,
  output logic [SCORE_W-1:0] scoreA,
  output logic [SCORE_W-1:0] scoreB,
  output logic [SCORE_W-1:0] draws,
  output logic [RND_W-1:0]   round_cnt,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               err_both
);

  // Reject configurations the counters cannot represent
  if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W - 1) || MAX_ROUNDS < 1) begin : g_bad_cfg
    $error("rps_match_scorer: illegal WIN_TARGET/SCORE_W/MAX_ROUNDS combination");
  end

  match_state_e  state, state_nxt;
  match_winner_e winner, winner_nxt;
  logic          err, err_nxt;

  logic accept, inc_a, inc_b, inc_d, hit_a, hit_b, clr;

  assign round_ready = (state == PLAY);
  // start drops any round offered in the same cycle
  assign accept      = round_valid & round_ready & ~start;
  assign inc_a       = accept &  winA & ~winB;
  assign inc_b       = accept & ~winA &  winB;
  assign inc_d       = accept & ~winA & ~winB;
  assign hit_a       = inc_a && (scoreA == SCORE_W'(WIN_TARGET - 1));
  assign hit_b       = inc_b && (scoreB == SCORE_W'(WIN_TARGET - 1));
  assign clr         = rst | start;

  rps_sat_counter #(.W(SCORE_W)) u_score_a (.clk(clk), .clr(clr), .en(inc_a),  .cnt(scoreA));
  rps_sat_counter #(.W(SCORE_W)) u_score_b (.clk(clk), .clr(clr), .en(inc_b),  .cnt(scoreB));
  rps_sat_counter #(.W(SCORE_W)) u_draws   (.clk(clk), .clr(clr), .en(inc_d),  .cnt(draws));
  rps_sat_counter #(.W(RND_W))   u_rounds  (.clk(clk), .clr(clr), .en(accept), .cnt(round_cnt));

`ifdef RPS_ROUND_LIMIT_EN
  logic               lim_hit;
  logic [SCORE_W-1:0] a_nxt, b_nxt;
  // Limit verdict compares the scores including the round being accepted
  assign lim_hit = accept && (round_cnt == RND_W'(MAX_ROUNDS - 1));
  assign a_nxt   = scoreA + SCORE_W'(inc_a);
  assign b_nxt   = scoreB + SCORE_W'(inc_b);
`endif

  // State, verdict and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      winner <= WIN_NONE;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      winner <= winner_nxt;
      err    <= err_nxt;
    end
  end

  // Next-state and verdict decode; target win takes precedence over round limit
  always_comb begin
    state_nxt  = state;
    winner_nxt = winner;
    err_nxt    = err;
    if (start) begin
      state_nxt  = PLAY;
      winner_nxt = WIN_NONE;
      err_nxt    = 1'b0;
    end else if (state == PLAY && accept) begin
      if (winA && winB)
        err_nxt = 1'b1;
      if (hit_a) begin
        state_nxt  = DONE;
        winner_nxt = WIN_A;
      end else if (hit_b) begin
        state_nxt  = DONE;
        winner_nxt = WIN_B;
      end
`ifdef RPS_ROUND_LIMIT_EN
      else if (lim_hit) begin
        state_nxt = DONE;
        if (a_nxt > b_nxt)
          winner_nxt = WIN_A;
        else if (b_nxt > a_nxt)
          winner_nxt = WIN_B;
        else
          winner_nxt = WIN_TIE;
      end
`endif
    end
  end

  assign match_done   = (state == DONE);
  assign match_winner = winner;
  assign err_both     = err;

endmodule
